// File: rtl/ctrl_encode_def.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def : shared control encodings for the pipelined MIPS core.
//   ALUOP_WIDTH      - width of the shared ALU operation code
//   ALU_*            - ALU operation codes
//   WD_*             - writeback data select (ALU result / memory / PC+4)
//   GPR_*            - destination register select (rd / rt / $31)
// ---------------------------------------------------------------------------
package ctrl_encode_def;

   localparam int ALUOP_WIDTH = 5;

   localparam logic [ALUOP_WIDTH-1:0] ALU_NOP  = 5'd0;
   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 5'd1;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 5'd2;
   localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 5'd3;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 5'd4;
   localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 5'd5;
   localparam logic [ALUOP_WIDTH-1:0] ALU_NOR  = 5'd6;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 5'd7;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = 5'd8;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = 5'd9;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = 5'd10;
   localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = 5'd11;
   localparam logic [ALUOP_WIDTH-1:0] ALU_LUI  = 5'd12;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC4 = 2'd2;

   localparam logic [1:0] GPR_RD = 2'd0;
   localparam logic [1:0] GPR_RT = 2'd1;
   localparam logic [1:0] GPR_31 = 2'd2;

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect : combinational load-use hazard detector.
//   rst            - reset; suppresses the stall request
//   ex_valid/ex_mem_read/ex_rt - load currently sitting in EX
//   id_valid/id_rs/id_rt/id_uses_rt - instruction currently in ID
//   flush          - taken branch kills the ID slot, so no stall is needed
//   load_use_stall - freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module hazard_detect (
   input  logic       rst,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       flush,
   output logic       load_use_stall
);

   logic src_match;
   logic hazard;

   // rt only counts as a source for instructions that actually read it
   assign src_match = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));

   // $0 is hardwired to zero, so a load into it never creates a dependency
   assign hazard = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid & src_match;

   assign load_use_stall = hazard & ~flush & ~rst;

endmodule

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg : ID/EX pipeline register of the pipelined MIPS core.
//   clk, rst          - clock, synchronous active-high reset
//   id_*              - decode results (PC, GPR data, Imm32, reg numbers, ctrl)
//   ex_stall          - hold current contents
//   flush             - replace the slot with a bubble
//   ex_*, ex_valid    - registered copies presented to EX
//   load_use_stall    - combinational stall request for PC and IF/ID
//   bubble_cnt        - saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_reg
   import ctrl_encode_def::*;
#(
   parameter int ALUOP_W = ALUOP_WIDTH,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [31:0]        id_pc,
   input  logic [31:0]        id_rd1,
   input  logic [31:0]        id_rd2,
   input  logic [31:0]        id_imm32,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic [4:0]         id_rd,
   input  logic               id_uses_rt,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic               id_alu_src,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic [1:0]         id_wd_sel,
   input  logic [1:0]         id_gpr_sel,
   input  logic               ex_stall,
   input  logic               flush,
   output logic [31:0]        ex_pc,
   output logic [31:0]        ex_rd1,
   output logic [31:0]        ex_rd2,
   output logic [31:0]        ex_imm32,
   output logic [4:0]         ex_rs,
   output logic [4:0]         ex_rt,
   output logic [4:0]         ex_rd,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alu_src,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [1:0]         ex_wd_sel,
   output logic [1:0]         ex_gpr_sel,
   output logic               ex_valid,
   output logic               load_use_stall,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic [31:0]        pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
   logic               alu_src_q, alu_src_d, reg_write_q, reg_write_d;
   logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [1:0]         wd_sel_q, wd_sel_d, gpr_sel_q, gpr_sel_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic bubble, load, count;

   hazard_detect u_hazard (
      .rst            (rst),
      .ex_valid       (valid_q),
      .ex_mem_read    (mem_read_q),
      .ex_rt          (rt_q),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rt     (id_uses_rt),
      .flush          (flush),
      .load_use_stall (load_use_stall)
   );

   // flush beats ex_stall; under ex_stall a pending hazard only holds
   // (load_use_stall already excludes flush)
   assign bubble = flush | (~ex_stall & load_use_stall);
   assign load   = ~flush & ~ex_stall & ~load_use_stall;
   assign count  = ~flush & ~ex_stall & load_use_stall;

   always_comb begin
      pc_d        = pc_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      alu_op_d    = alu_op_q;
      alu_src_d   = alu_src_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      wd_sel_d    = wd_sel_q;
      gpr_sel_d   = gpr_sel_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      if (bubble) begin
         pc_d        = '0;
         rd1_d       = '0;
         rd2_d       = '0;
         imm_d       = '0;
         rs_d        = '0;
         rt_d        = '0;
         rd_d        = '0;
         alu_op_d    = '0;
         alu_src_d   = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         wd_sel_d    = WD_ALU;
         gpr_sel_d   = GPR_RD;
         valid_d     = 1'b0;
      end else if (load) begin
         pc_d        = id_pc;
         rd1_d       = id_rd1;
         rd2_d       = id_rd2;
         imm_d       = id_imm32;
         rs_d        = id_rs;
         rt_d        = id_rt;
         rd_d        = id_rd;
         alu_op_d    = id_alu_op;
         alu_src_d   = id_alu_src;
         wd_sel_d    = id_wd_sel;
         gpr_sel_d   = id_gpr_sel;
         // a dead slot carries its fields along but must never change state
         reg_write_d = id_reg_write & id_valid;
         mem_read_d  = id_mem_read & id_valid;
         mem_write_d = id_mem_write & id_valid;
         valid_d     = id_valid;
      end
      if (count && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         alu_op_q    <= '0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         wd_sel_q    <= '0;
         gpr_sel_q   <= '0;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         pc_q        <= pc_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         alu_op_q    <= alu_op_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         wd_sel_q    <= wd_sel_d;
         gpr_sel_q   <= gpr_sel_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ex_pc        = pc_q;
   assign ex_rd1       = rd1_q;
   assign ex_rd2       = rd2_q;
   assign ex_imm32     = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign ex_alu_op    = alu_op_q;
   assign ex_alu_src   = alu_src_q;
   assign ex_reg_write = reg_write_q;
   assign ex_mem_read  = mem_read_q;
   assign ex_mem_write = mem_write_q;
   assign ex_wd_sel    = wd_sel_q;
   assign ex_gpr_sel   = gpr_sel_q;
   assign ex_valid     = valid_q;
   assign bubble_cnt   = cnt_q;

endmodule
